// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel pipeline (window buffer and gradient stages).
package sobel_pkg;
    localparam int PIX_W_DEF      = 8;
    localparam int IMG_WIDTH_DEF  = 640;
    localparam int IMG_HEIGHT_DEF = 480;
    localparam int WIN_SIZE       = 3;

    typedef logic [PIX_W_DEF-1:0] pixel_t;
endpackage

// File: rtl/sobel_line_buffer.sv
// Fixed DEPTH-beat delay line: circular RAM, single wrapping pointer, advances only on en.
// dout is the pixel written DEPTH accepted beats ago (read before overwrite).
module sobel_line_buffer #(
    parameter int DEPTH = 640,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] dout
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [PIX_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;

    assign dout  = mem_q[ptr_q];
    assign ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (en) begin
            ptr_q <= ptr_d;
        end
    end

    // Contents are deliberately left unreset; stale rows are masked downstream.
    always_ff @(posedge clk) begin
        if (en) begin
            mem_q[ptr_q] <= din;
        end
    end
endmodule

// File: rtl/sobel_window_buffer.sv
// Raster-order 3x3 window generator: two line buffers feed a registered window,
// flagged with start_calculations for every interior pixel and frame_done on the last.
module sobel_window_buffer
    import sobel_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int PIX_W      = PIX_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    input  logic             sof,
    output logic [PIX_W-1:0] P0,
    output logic [PIX_W-1:0] P1,
    output logic [PIX_W-1:0] P2,
    output logic [PIX_W-1:0] P3,
    output logic [PIX_W-1:0] P4,
    output logic [PIX_W-1:0] P5,
    output logic [PIX_W-1:0] P6,
    output logic [PIX_W-1:0] P7,
    output logic [PIX_W-1:0] P8,
    output logic             start_calculations,
    output logic             frame_done
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0]    col_q, col_d, cur_col;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic             last_col, last_row;
    logic             start_q, start_d, done_q, done_d;
    logic [PIX_W-1:0] lb1_out, lb2_out;
    logic [PIX_W-1:0] col_in [WIN_SIZE];
    logic [PIX_W-1:0] win_q  [WIN_SIZE][WIN_SIZE];

    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb1 (
        .clk(clk), .rst(rst), .en(pix_valid), .din(pix_in), .dout(lb1_out)
    );
    sobel_line_buffer #(.DEPTH(IMG_WIDTH), .PIX_W(PIX_W)) u_lb2 (
        .clk(clk), .rst(rst), .en(pix_valid), .din(lb1_out), .dout(lb2_out)
    );

    assign col_in[0] = lb2_out;
    assign col_in[1] = lb1_out;
    assign col_in[2] = pix_in;

    // sof re-labels the current beat as (0,0), aborting whatever frame was in flight.
    always_comb begin
        cur_col  = sof ? '0 : col_q;
        cur_row  = sof ? '0 : row_q;
        last_col = (cur_col == COL_LAST);
        last_row = (cur_row == ROW_LAST);
        col_d    = col_q;
        row_d    = row_q;
        if (pix_valid) begin
            col_d = last_col ? '0 : cur_col + 1'b1;
            if (last_col) begin
                row_d = last_row ? '0 : cur_row + 1'b1;
            end else begin
                row_d = cur_row;
            end
        end
        start_d = pix_valid && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
        done_d  = pix_valid && last_row && last_col;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < WIN_SIZE; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            start_q <= start_d;
            done_q  <= done_d;
            if (pix_valid) begin
                for (int r = 0; r < WIN_SIZE; r++) begin
                    for (int c = 0; c < WIN_SIZE - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                    win_q[r][WIN_SIZE-1] <= col_in[r];
                end
            end
        end
    end

    assign P0 = win_q[0][0];
    assign P1 = win_q[0][1];
    assign P2 = win_q[0][2];
    assign P3 = win_q[1][0];
    assign P4 = win_q[1][1];
    assign P5 = win_q[1][2];
    assign P6 = win_q[2][0];
    assign P7 = win_q[2][1];
    assign P8 = win_q[2][2];

    assign start_calculations = start_q;
    assign frame_done         = done_q;
endmodule

// File: tb/tb_sobel_window_buffer.sv
// Scoreboard bench for sobel_window_buffer on a 5x5 image with ramp pixels row*16+col+base.
module tb_sobel_window_buffer;
    localparam int W = 5;
    localparam int H = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_in = '0;
    logic       pix_valid = 1'b0;
    logic       sof = 1'b0;
    logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
    logic       start_calculations, frame_done;

    sobel_window_buffer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_W(8)) dut (
        .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
        .P0(P0), .P1(P1), .P2(P2), .P3(P3), .P4(P4), .P5(P5), .P6(P6), .P7(P7), .P8(P8),
        .start_calculations(start_calculations), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] win;
        logic        fd;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_pulses = 0;
    logic [71:0] cur_win;
    logic [71:0] prev_win = '0;
    bit          mon_started = 0;
    bit          last_acc = 0;
    bit          last_rst = 0;

    assign cur_win = {P0, P1, P2, P3, P4, P5, P6, P7, P8};

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: inputs change at posedge+1, so at negedge they describe the coming edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_started) begin
            if (last_rst) begin
                check("reset_window", cur_win, 72'h0);
                check("reset_strobes", {70'h0, start_calculations, frame_done}, 72'h0);
            end else if (!last_acc) begin
                check("idle_no_strobe", {70'h0, start_calculations, frame_done}, 72'h0);
                check("idle_window_hold", cur_win, prev_win);
            end
            if (start_calculations) begin
                n_pulses++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got window %h expected no pulse", cur_win);
                end else begin
                    e = sb_q.pop_front();
                    check("window", cur_win, e.win);
                    check("frame_done", {71'h0, frame_done}, {71'h0, e.fd});
                end
            end else if (frame_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL frame_done_alone: got 1 expected 0 without start_calculations");
            end
        end
        prev_win    = cur_win;
        last_acc    = pix_valid && !rst;
        last_rst    = rst;
        mon_started = 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t make_exp(input logic [7:0] base, input int r, input int c);
        exp_t e;
        e.win = '0;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] v;
            v = base + 8'((r - 2 + i / 3) * 16 + (c - 2 + i % 3));
            e.win[71 - i*8 -: 8] = v;
        end
        e.fd = (r == H - 1) && (c == W - 1);
        return e;
    endfunction

    // Streams beats 0..n_beats-1 of a frame; an expected window is queued for each interior pixel.
    task automatic run_frame(input logic [7:0] base, input bit first_sof, input int gap,
                             input int n_beats, input int lone_sof_at);
        for (int k = 0; k < n_beats; k++) begin
            int r, c;
            r = k / W;
            c = k % W;
            pix_in    = base + 8'(r * 16 + c);
            sof       = first_sof && (k == 0);
            pix_valid = 1'b1;
            if (r >= 2 && c >= 2) sb_q.push_back(make_exp(base, r, c));
            tick();
            pix_valid = 1'b0;
            sof       = 1'b0;
            pix_in    = 8'hEE;
            if (gap > 0 && (k % 2) == 1) begin
                for (int g = 0; g < gap; g++) tick();
            end
            if (k == lone_sof_at) begin
                sof = 1'b1;
                tick();
                sof = 1'b0;
            end
        end
    endtask

    task automatic drain_and_count(input string name, input int base_pulses, input int want);
        tick();
        tick();
        check(name, 72'(n_pulses - base_pulses), 72'(want));
        check({name, "_queue_empty"}, 72'(sb_q.size()), 72'h0);
    endtask

    initial begin
        int p;
        rst = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();

        p = n_pulses;
        run_frame(8'h00, 1'b1, 0, W * H, -1);
        drain_and_count("frame_continuous_pulses", p, 9);

        p = n_pulses;
        run_frame(8'h00, 1'b1, 3, W * H, -1);
        drain_and_count("frame_gapped_pulses", p, 9);

        p = n_pulses;
        run_frame(8'h00, 1'b1, 0, W * H, -1);
        run_frame(8'h80, 1'b1, 0, W * H, -1);
        drain_and_count("back_to_back_pulses", p, 18);

        // Abort frame 1 at (3,1): that pixel becomes (0,0) of a new frame.
        p = n_pulses;
        run_frame(8'h00, 1'b1, 0, 3 * W + 1, -1);
        run_frame(8'h80, 1'b1, 0, W * H, -1);
        drain_and_count("sof_abort_pulses", p, 12);

        // Reset during the beat that would be (2,3); a lone sof appears mid-row afterwards.
        p = n_pulses;
        run_frame(8'h00, 1'b1, 0, 2 * W + 3, -1);
        pix_in    = 8'h23;
        pix_valid = 1'b1;
        rst       = 1'b1;
        tick();
        rst       = 1'b0;
        pix_valid = 1'b0;
        tick();
        run_frame(8'h40, 1'b0, 0, W * H, 7);
        drain_and_count("reset_recovery_pulses", p, 10);

        check("total_pulses", 72'(n_pulses), 72'd58);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1);
    end
endmodule
